// File: rtl/vx_pipe_elastic_reg.sv
// ---------------------------------------------------------------------------
// vx_pipe_elastic_reg
//
// Elastic pipeline register between two pipeline stages. It carries a packed
// scalar sideband, a warp number, a per-thread mask and per-thread lane data.
// Storage is a main (head) entry plus one skid entry. Because of the skid
// entry, in_ready is derived only from registered state and in_freeze, and
// never from out_ready. This breaks the combinational stall path.
//
// Ports
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   producer handshake
//   in_thread_mask      per-thread valid mask (an all-zero mask is a bubble)
//   in_warp_num         warp id
//   in_data             scalar sideband
//   in_lane_data        per-thread data, lane i at [32i+31:32i]
//   in_flush            synchronous squash of every held entry
//   in_freeze           hold all state, block both handshakes
//   out_valid/out_ready consumer handshake
//   out_*               fields of the head entry
//   out_count           number of entries held (0..2)
//   stall_cycles        saturating count of cycles with out_valid & ~out_ready
// ---------------------------------------------------------------------------
module vx_pipe_elastic_reg #(
    parameter int DATAW = 128,
    parameter int NT    = 4,
    parameter int NWB   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NT-1:0]        in_thread_mask,
    input  logic [NWB-1:0]       in_warp_num,
    input  logic [DATAW-1:0]     in_data,
    input  logic [NT*32-1:0]     in_lane_data,

    input  logic                 in_flush,
    input  logic                 in_freeze,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NT-1:0]        out_thread_mask,
    output logic [NWB-1:0]       out_warp_num,
    output logic [DATAW-1:0]     out_data,
    output logic [NT*32-1:0]     out_lane_data,

    output logic [1:0]           out_count,
    output logic [31:0]          stall_cycles
);

    // One stored entry packed as {mask, warp, sideband, lane data}.
    localparam int LW = NT * 32;
    localparam int EW = NT + NWB + DATAW + LW;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   main_q,  main_d;
    logic [EW-1:0]   skid_q,  skid_d;
    logic [31:0]     stall_q, stall_d;

    logic [EW-1:0]   in_entry;
    logic            acc;
    logic            deq;

    assign in_entry = {in_thread_mask, in_warp_num, in_data, in_lane_data};

    // Handshake outputs. reset_n is folded into in_ready so that the producer
    // sees "not ready" for as long as reset is asserted.
    assign in_ready  = (state_q != ST_FULL) & ~in_freeze & reset_n;
    assign out_valid = (state_q != ST_EMPTY) & ~in_freeze;

    // An all-zero thread mask is still handshaken (consumed) but never stored.
    assign acc = in_valid & in_ready & (|in_thread_mask);
    assign deq = out_valid & out_ready;

    // The head entry drives the outputs directly. Its payload may be stale
    // while out_valid is low.
    assign out_thread_mask = main_q[EW-1 -: NT];
    assign out_warp_num    = main_q[EW-NT-1 -: NWB];
    assign out_data        = main_q[LW +: DATAW];
    assign out_lane_data   = main_q[LW-1:0];

    assign out_count    = (state_q == ST_FULL) ? 2'd2 :
                          (state_q == ST_ONE)  ? 2'd1 : 2'd0;
    assign stall_cycles = stall_q;

    // Next-state and datapath.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        stall_d = stall_q;

        if (in_flush) begin
            // Flush wins over freeze and over any transfer. The skid payload
            // is simply left stale because the state marks it invalid.
            state_d = ST_EMPTY;
        end else if (!in_freeze) begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        main_d  = in_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && deq) begin
                        main_d = in_entry;
                    end else if (acc) begin
                        skid_d  = in_entry;
                        state_d = ST_FULL;
                    end else if (deq) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a dequeue can happen.
                    if (deq) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        // out_valid is already low under freeze, so the counter holds then.
        if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_vx_pipe_elastic_reg.sv
// ---------------------------------------------------------------------------
// tb_vx_pipe_elastic_reg
//
// Bench for vx_pipe_elastic_reg. A queue of at most two entries models the
// block. Every cycle, the DUT outputs are compared against the queue, and the
// queue is then advanced by the handshake rules. Directed scenarios come
// first, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_vx_pipe_elastic_reg;

    localparam int DATAW = 128;
    localparam int NT    = 4;
    localparam int NWB   = 2;
    localparam int LW    = NT * 32;

    typedef struct packed {
        logic [NT-1:0]    m;
        logic [NWB-1:0]   w;
        logic [DATAW-1:0] d;
        logic [LW-1:0]    l;
    } ent_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [NT-1:0]    in_thread_mask = '0;
    logic [NWB-1:0]   in_warp_num = '0;
    logic [DATAW-1:0] in_data = '0;
    logic [LW-1:0]    in_lane_data = '0;
    logic             in_flush = 1'b0;
    logic             in_freeze = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [NT-1:0]    out_thread_mask;
    logic [NWB-1:0]   out_warp_num;
    logic [DATAW-1:0] out_data;
    logic [LW-1:0]    out_lane_data;
    logic [1:0]       out_count;
    logic [31:0]      stall_cycles;

    vx_pipe_elastic_reg #(.DATAW(DATAW), .NT(NT), .NWB(NWB)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_thread_mask  (in_thread_mask),
        .in_warp_num     (in_warp_num),
        .in_data         (in_data),
        .in_lane_data    (in_lane_data),
        .in_flush        (in_flush),
        .in_freeze       (in_freeze),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_thread_mask (out_thread_mask),
        .out_warp_num    (out_warp_num),
        .out_data        (out_data),
        .out_lane_data   (out_lane_data),
        .out_count       (out_count),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: FIFO contents, stall counter, and log of delivered data.
    ent_t             mq[$];
    logic [31:0]      mstall = '0;
    logic [DATAW-1:0] drained[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare all DUT outputs with what the model says they must be now.
    task automatic compare_cycle();
        int  sz;
        bit  exp_ir;
        bit  exp_ov;
        sz     = mq.size();
        exp_ir = reset_n && (sz < 2) && !in_freeze;
        exp_ov = (sz > 0) && !in_freeze;
        chk("in_ready",     256'(in_ready),     256'(exp_ir));
        chk("out_valid",    256'(out_valid),    256'(exp_ov));
        chk("out_count",    256'(out_count),    256'(sz));
        chk("stall_cycles", 256'(stall_cycles), 256'(mstall));
        if (exp_ov) begin
            chk("out_thread_mask", 256'(out_thread_mask), 256'(mq[0].m));
            chk("out_warp_num",    256'(out_warp_num),    256'(mq[0].w));
            chk("out_data",        256'(out_data),        256'(mq[0].d));
            chk("out_lane_data",   256'(out_lane_data),   256'(mq[0].l));
        end
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        bit   exp_ir;
        bit   exp_ov;
        ent_t e;
        exp_ir = reset_n && (mq.size() < 2) && !in_freeze;
        exp_ov = (mq.size() > 0) && !in_freeze;
        if (exp_ov && !out_ready && mstall != 32'hFFFF_FFFF) mstall = mstall + 32'd1;
        if (in_flush) begin
            mq.delete();
        end else if (!in_freeze) begin
            if (exp_ov && out_ready) begin
                drained.push_back(mq[0].d);
                $display("xfer out: data=%0h mask=%b warp=%0d", mq[0].d, mq[0].m, mq[0].w);
                void'(mq.pop_front());
            end
            if (in_valid && exp_ir && (in_thread_mask != '0)) begin
                e.m = in_thread_mask;
                e.w = in_warp_num;
                e.d = in_data;
                e.l = in_lane_data;
                mq.push_back(e);
            end
        end
    endtask

    // One clock cycle. Called at a falling edge and returns at the next one.
    task automatic cycle(input bit v, input logic [NT-1:0] mask, input logic [DATAW-1:0] data,
                         input bit flush, input bit freeze, input bit ordy);
        in_valid       = v;
        in_thread_mask = mask;
        in_warp_num    = NWB'($urandom);
        in_data        = data;
        in_lane_data   = {$urandom, $urandom, $urandom, $urandom};
        in_flush       = flush;
        in_freeze      = freeze;
        out_ready      = ordy;
        #1;
        compare_cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int b;

        // Reset state.
        #2;
        chk("rst_in_ready",  256'(in_ready),     256'(0));
        chk("rst_out_valid", 256'(out_valid),    256'(0));
        chk("rst_out_count", 256'(out_count),    256'(0));
        chk("rst_out_data",  256'(out_data),     256'(0));
        chk("rst_stall",     256'(stall_cycles), 256'(0));
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready", 256'(in_ready), 256'(1));

        // 1: streaming with out_ready high.
        b = drained.size();
        for (int i = 0; i < 4; i++) cycle(1, 4'b1111, DATAW'(8'hA5 + i), 0, 0, 1);
        cycle(0, 4'b1111, '0, 0, 0, 1);
        chk("t1_drained_n", 256'(drained.size() - b), 256'(4));
        for (int i = 0; i < 4; i++)
            if (drained.size() > b + i) chk("t1_order", 256'(drained[b+i]), 256'(8'hA5 + i));

        // 2: back-pressure fills the skid, then drains in order.
        b = drained.size();
        cycle(1, 4'b1111, 'h11, 0, 0, 0);
        cycle(1, 4'b1111, 'h22, 0, 0, 0);
        chk("t2_full_count", 256'(out_count), 256'(2));
        cycle(1, 4'b1111, 'h33, 0, 0, 0);
        cycle(1, 4'b1111, 'h33, 0, 0, 1);
        cycle(1, 4'b1111, 'h33, 0, 0, 1);
        cycle(0, 4'b1111, '0, 0, 0, 1);
        chk("t2_drained_n", 256'(drained.size() - b), 256'(3));
        if (drained.size() == b + 3) begin
            chk("t2_first",  256'(drained[b]),   256'('h11));
            chk("t2_second", 256'(drained[b+1]), 256'('h22));
            chk("t2_third",  256'(drained[b+2]), 256'('h33));
        end
        chk("t2_stall", 256'(stall_cycles), 256'(2));

        // 3: flush while FULL drops both entries and the flush-cycle input.
        b = drained.size();
        cycle(1, 4'b1111, 'h11, 0, 0, 0);
        cycle(1, 4'b1111, 'h22, 0, 0, 0);
        cycle(1, 4'b1111, 'h44, 1, 0, 0);
        chk("t3_flush_valid", 256'(out_valid), 256'(0));
        chk("t3_flush_count", 256'(out_count), 256'(0));
        cycle(0, 4'b1111, '0, 0, 0, 1);
        cycle(0, 4'b1111, '0, 0, 0, 1);
        chk("t3_nothing_out", 256'(drained.size() - b), 256'(0));
        chk("t3_stall", 256'(stall_cycles), 256'(4));

        // 4: freeze holds the entry and blocks both handshakes.
        b = drained.size();
        cycle(1, 4'b1111, 'h55, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 4'b1111, 'h99, 0, 1, 1);
        chk("t4_frozen_count", 256'(out_count), 256'(1));
        chk("t4_frozen_ready", 256'(in_ready),  256'(0));
        cycle(0, 4'b1111, '0, 0, 0, 1);
        chk("t4_drained_n", 256'(drained.size() - b), 256'(1));
        if (drained.size() == b + 1) chk("t4_value", 256'(drained[b]), 256'('h55));

        // 5: zero-mask bubble is consumed but not stored.
        b = drained.size();
        cycle(1, 4'b0000, 'h66, 0, 0, 1);
        cycle(1, 4'b0101, 'h77, 0, 0, 1);
        chk("t5_mask", 256'(out_thread_mask), 256'(4'b0101));
        cycle(0, 4'b0000, '0, 0, 0, 1);
        chk("t5_drained_n", 256'(drained.size() - b), 256'(1));
        if (drained.size() == b + 1) chk("t5_value", 256'(drained[b]), 256'('h77));

        // 6: asynchronous reset while FULL.
        cycle(1, 4'b1111, 'h11, 0, 0, 0);
        cycle(1, 4'b1111, 'h22, 0, 0, 0);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", 256'(out_valid),    256'(0));
        chk("t6_rst_ready", 256'(in_ready),     256'(0));
        chk("t6_rst_count", 256'(out_count),    256'(0));
        chk("t6_rst_stall", 256'(stall_cycles), 256'(0));
        mq.delete();
        mstall = '0;
        @(negedge clk);
        reset_n = 1'b1;
        b = drained.size();
        cycle(1, 4'b1111, 'h88, 0, 0, 1);
        cycle(0, 4'b1111, '0, 0, 0, 1);
        cycle(0, 4'b1111, '0, 0, 0, 1);
        chk("t6_drained_n", 256'(drained.size() - b), 256'(1));
        if (drained.size() == b + 1) chk("t6_value", 256'(drained[b]), 256'('h88));

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? 4'b0000 : NT'($urandom),
                  {$urandom, $urandom, $urandom, $urandom},
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vx_pipe_elastic_reg.md
Name: vx_pipe_elastic_reg

Overview:
- Parametrised, elastic successor of the fixed execute/memory pipeline register.
- Carries a packed scalar sideband and per-thread lane data between any two pipeline stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is registered and breaks the combinational stall path.
- Adds synchronous flush, freeze, bubble squashing of all-zero thread masks, occupancy output and a saturating back-pressure counter.

Parameters:
- DATAW, 128: width of packed scalar sideband (rd, wb, PC, CSR, branch fields, etc.).
- NT, 4: threads per warp; lane data is NT*32 bits and the thread mask is NT bits.
- NWB, 2: warp-number width.

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  producer has an entry
- in_ready  out  1  block can accept an entry
- in_thread_mask  in  NT  per-thread valid mask
- in_warp_num  in  NWB  warp id
- in_data  in  DATAW  scalar sideband
- in_lane_data  in  NT*32  per-thread data; lane i occupies bits [32i+31:32i]
- in_flush  in  1  squash all held entries
- in_freeze  in  1  hold all state
- out_valid  out  1  head entry presented
- out_ready  in  1  consumer accepts
- out_thread_mask, out_warp_num, out_data, out_lane_data  out  NT/NWB/DATAW/NT*32  head entry fields
- out_count  out  2  entries held (0..2)
- stall_cycles  out  32  back-pressure cycle counter

Behaviour:
- Storage is a main entry (head, drives the out_* fields) plus a skid entry. States:
  - EMPTY: neither entry valid.
  - ONE: main entry valid.
  - FULL: main and skid entries valid.
- Definitions:
  - acc = in_valid & in_ready & (|in_thread_mask).
  - deq = out_valid & out_ready.
- in_ready = (state != FULL) & ~in_freeze & reset_n. in_ready depends only on registered state plus in_freeze; it never depends on out_ready.
- out_valid = (state != EMPTY) & ~in_freeze.
- Bubble rule: in_valid & in_ready with in_thread_mask == 0 is consumed but not stored. There is no state change.
- Transitions, evaluated when neither in_flush nor in_freeze is active:
  - EMPTY: acc -> main <= in, go to ONE.
  - ONE:
    - acc & deq -> main <= in, stay in ONE.
    - acc only -> skid <= in, go to FULL.
    - deq only -> go to EMPTY.
    - neither -> hold.
  - FULL: deq -> main <= skid, go to ONE. No accept is possible in FULL.
- Ordering is strictly FIFO. An entry accepted at edge N is visible on out_* after edge N when the block was EMPTY. Latency is 1 cycle.
- in_flush (synchronous) has priority over in_freeze and over acc/deq:
  - Next state is EMPTY and the skid entry is discarded.
  - Input presented in the flush cycle is dropped.
  - in_ready is unaffected in that cycle.
- in_freeze (without in_flush): all registers hold, including stall_cycles. in_ready = out_valid = 0.
- Data registers load only on a transfer. Payload fields of an invalid entry keep stale values; only out_valid qualifies them.
- out_count = 0/1/2 for EMPTY/ONE/FULL.
- stall_cycles increments when out_valid & ~out_ready, saturates at 32'hFFFF_FFFF, and is not cleared by flush.
- Reset (reset_n low, asynchronous):
  - state EMPTY; in_ready = 0, out_valid = 0, out_count = 0.
  - All data, mask and warp registers = 0; stall_cycles = 0.
  - in_ready rises combinationally once reset_n is high.
  - Reset asserted mid-transfer discards all entries; there is no partial update.

Test Plan:
1. Post-reset, in_valid=1, mask=4'b1111, data=0xA5, out_ready=1 for 4 cycles with data 0xA5,0xA6,0xA7,0xA8 -> out_valid from cycle 1; out_data 0xA5..0xA8 in order; out_count stays 1; in_ready stays 1.
2. out_ready=0, push 0x11, then 0x22 -> out_count 1, then 2; in_ready=0 after 2nd edge. Push 0x33 is held off. Raise out_ready -> outputs 0x11, 0x22, 0x33 in order with no loss; stall_cycles equals the cycles where out_valid=1 and out_ready=0.
3. FULL with 0x11/0x22, assert in_flush one cycle with in_valid=1 data 0x44 -> next cycle out_valid=0, out_count=0; 0x44 is never output.
4. ONE with 0x55, in_freeze=1 for 3 cycles with in_valid=1 and out_ready=1 -> in_ready=out_valid=0; 0x55 and out_count=1 are retained; output resumes with 0x55 after freeze drops.
5. in_valid=1 with mask=0 and data 0x66, then mask=4'b0101 with data 0x77 -> 0x66 is dropped; 0x77 is output with out_thread_mask=4'b0101 and lane data intact.
6. FULL, drop reset_n asynchronously mid-cycle -> out_valid, in_ready and out_count go to 0 immediately; after release, a fresh push of 0x88 appears alone.
